// File: rtl/fifo_share_arb_if.sv
// Write-side bundle between the requesters, the shared-FIFO arbiter and the FIFO write port.
// Define FIFO_SHARE_ARB_TAG_EN to widen din with the requester index.
interface fifo_share_arb_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 4
);
    localparam int IDW = $clog2(NREQ);
`ifdef FIFO_SHARE_ARB_TAG_EN
    localparam int DINW = DWIDTH + IDW;
`else
    localparam int DINW = DWIDTH;
`endif

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0][DWIDTH-1:0]  req_data;
    logic [NREQ-1:0]              req_ready;
    logic                         full;
    logic                         wen;
    logic [DINW-1:0]              din;
    logic [IDW-1:0]               grant_id;
    logic                         busy;

    modport master (
        output req_valid, req_data, full,
        input  req_ready, wen, din, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, full,
        output req_ready, wen, din, grant_id, busy
    );
endinterface

// File: rtl/fifo_share_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// Optional FIFO_SHARE_ARB_TAG_EN prepends grant_id to the FIFO write data.
module fifo_share_arb #(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 4,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_share_arb_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int BCW = $clog2(MAXBURST + 1);
`ifdef FIFO_SHARE_ARB_TAG_EN
    localparam int DINW = DWIDTH + IDW;
`else
    localparam int DINW = DWIDTH;
`endif

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [IDW-1:0]   grant_id_r;
    logic [IDW-1:0]   grant_id_nxt_s;
    logic [BCW-1:0]   burst_cnt_r;
    logic [BCW-1:0]   burst_cnt_nxt_s;
    logic             busy_r;
    logic [IDW:0]     pick_s;
    logic [NREQ-1:0]  req_ready_s;
    logic             wen_s;
    logic [DINW-1:0]  din_s;

    // First valid requester strictly after ptr, wrapping modulo NREQ; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] pick;
        int           idx;
        pick = {(IDW+1){1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (valid[idx[IDW-1:0]]) begin
                pick = {1'b1, idx[IDW-1:0]};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Next-state logic: grant selection in IDLE, burst accounting and release in BUSY.
    always_comb begin
        state_nxt_s     = state_r;
        grant_id_nxt_s  = grant_id_r;
        burst_cnt_nxt_s = burst_cnt_r;
        pick_s          = rr_pick(bus.req_valid, grant_id_r);
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IDW] && !bus.full) begin
                    state_nxt_s     = ST_BUSY;
                    grant_id_nxt_s  = pick_s[IDW-1:0];
                    burst_cnt_nxt_s = {BCW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.full) begin
                    state_nxt_s = ST_BUSY;
                end else if (!bus.req_valid[grant_id_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    burst_cnt_nxt_s = burst_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
                    if (burst_cnt_nxt_s == BCW'(MAXBURST)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Zero-latency data path: only the locked requester sees ready, gated by FIFO full.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (state_r == ST_BUSY) begin
            req_ready_s[grant_id_r] = ~bus.full;
            wen_s = bus.req_valid[grant_id_r] & ~bus.full;
        end else begin
            wen_s = 1'b0;
        end
`ifdef FIFO_SHARE_ARB_TAG_EN
        din_s = {grant_id_r, bus.req_data[grant_id_r]};
`else
        din_s = bus.req_data[grant_id_r];
`endif
    end

    // State registers; grant_id resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_id_r  <= IDW'(NREQ - 1);
            burst_cnt_r <= {BCW{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_id_r  <= grant_id_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            busy_r      <= (state_nxt_s == ST_BUSY);
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.wen       = wen_s;
    assign bus.din       = din_s;
    assign bus.grant_id  = grant_id_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_fifo_share_arb.sv
// Directed self-checking bench for fifo_share_arb (NREQ=4, DWIDTH=4, MAXBURST=4).
module tb_fifo_share_arb;
    localparam int NREQ = 4;
    localparam int DWIDTH = 4;
    localparam int IDW = 2;
`ifdef FIFO_SHARE_ARB_TAG_EN
    localparam int DINW = DWIDTH + IDW;
`else
    localparam int DINW = DWIDTH;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fifo_share_arb_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    fifo_share_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAXBURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DINW-1:0] exp_din(input logic [IDW-1:0] id, input logic [DWIDTH-1:0] d);
`ifdef FIFO_SHARE_ARB_TAG_EN
        return {id, d};
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b0000;
        bus.full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.full = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data[0] = 4'h1; bus.req_data[1] = 4'h2;
        bus.req_data[2] = 4'h3; bus.req_data[3] = 4'hD;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", bus.wen); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
        checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d exp 3", bus.grant_id); end
        checks++; if (bus.din !== exp_din(2'd3, 4'hD)) begin errors++; $display("FAIL reset_din got %h exp %h", bus.din, exp_din(2'd3, 4'hD)); end
    endtask

    task automatic test_single();
        logic exp_w [1:7];
        exp_w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        bus.req_data[2] = 4'hA;
        bus.req_valid = 4'b0100;
        for (int k = 1; k <= 7; k++) begin
            tick(); #1;
            checks++; if (bus.wen !== exp_w[k] || bus.busy !== exp_w[k]) begin errors++; $display("FAIL single_c%0d wen/busy got %b/%b exp %b", k, bus.wen, bus.busy, exp_w[k]); end
            checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_c%0d got %0d exp 2", k, bus.grant_id); end
        end
        checks++; if (bus.din !== exp_din(2'd2, 4'hA)) begin errors++; $display("FAIL single_din got %h exp %h", bus.din, exp_din(2'd2, 4'hA)); end
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", bus.req_ready); end
    endtask

    task automatic test_all_valid();
        int writes;
        logic exp_w;
        logic [1:0] exp_g;
        writes = 0;
        do_reset();
        bus.req_data[0] = 4'h1; bus.req_data[1] = 4'h2;
        bus.req_data[2] = 4'h3; bus.req_data[3] = 4'h4;
        bus.req_valid = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            tick(); #1;
            exp_w = ((k - 1) % 5) != 4;
            exp_g = 2'(((k - 1) / 5) % 4);
            if (bus.wen === 1'b1) writes++;
            checks++; if (bus.wen !== exp_w) begin errors++; $display("FAIL all_wen_c%0d got %b exp %b", k, bus.wen, exp_w); end
            checks++; if (bus.grant_id !== exp_g) begin errors++; $display("FAIL all_grant_c%0d got %0d exp %0d", k, bus.grant_id, exp_g); end
            checks++; if (bus.din !== exp_din(exp_g, DWIDTH'(exp_g + 2'd1))) begin errors++; $display("FAIL all_din_c%0d got %h", k, bus.din); end
        end
        checks++; if (writes != 16) begin errors++; $display("FAIL all_writes got %0d exp 16", writes); end
        tick(); #1;
        checks++; if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL all_wrap got %0d/%b exp 0/1", bus.grant_id, bus.busy); end
    endtask

    task automatic test_full();
        logic exp_w [1:11];
        logic exp_b [1:11];
        exp_w = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        bus.req_data[0] = 4'h7;
        bus.req_valid = 4'b0001;
        for (int k = 1; k <= 11; k++) begin
            tick();
            bus.full = (k >= 3 && k <= 7);
            #1;
            checks++; if (bus.wen !== exp_w[k] || bus.req_ready[0] !== exp_w[k]) begin errors++; $display("FAIL full_c%0d wen/ready got %b/%b exp %b", k, bus.wen, bus.req_ready[0], exp_w[k]); end
            checks++; if (bus.busy !== exp_b[k] || bus.grant_id !== 2'd0) begin errors++; $display("FAIL full_hold_c%0d busy/grant got %b/%0d exp %b/0", k, bus.busy, bus.grant_id, exp_b[k]); end
        end
    endtask

    task automatic test_early_drop(input logic [3:0] others, input logic [1:0] exp_next);
        do_reset();
        bus.req_valid = 4'b0010;
        tick(); #1;
        checks++; if (bus.grant_id !== 2'd1 || bus.wen !== 1'b1) begin errors++; $display("FAIL drop_grant got %0d/%b exp 1/1", bus.grant_id, bus.wen); end
        tick();
        bus.req_valid = others;
        #1;
        checks++; if (bus.wen !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL drop_cycle wen/busy got %b/%b exp 0/1", bus.wen, bus.busy); end
        tick(); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_release got %b exp 0", bus.busy); end
        tick(); #1;
        checks++; if (bus.grant_id !== exp_next || bus.busy !== 1'b1) begin errors++; $display("FAIL drop_next got %0d/%b exp %0d/1", bus.grant_id, bus.busy, exp_next); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req_valid = 4'b1000;
        tick(); tick(); #1;
        checks++; if (bus.grant_id !== 2'd3 || bus.wen !== 1'b1) begin errors++; $display("FAIL arst_pre got %0d/%b exp 3/1", bus.grant_id, bus.wen); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wen !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL arst_now wen/busy/ready got %b/%b/%b exp 0/0/0000", bus.wen, bus.busy, bus.req_ready); end
        checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL arst_grant got %0d exp 3", bus.grant_id); end
        bus.req_valid = 4'b1001;
        tick();
        rst_n = 1'b1;
        tick(); #1;
        checks++; if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL arst_first got %0d/%b exp 0/1", bus.grant_id, bus.busy); end
    endtask

    task automatic test_tag();
        do_reset();
        bus.req_data[2] = 4'h5;
        bus.req_valid = 4'b0100;
        tick(); #1;
`ifdef FIFO_SHARE_ARB_TAG_EN
        checks++; if (bus.din !== 6'h25 || bus.wen !== 1'b1) begin errors++; $display("FAIL tag_din got %h/%b exp 25/1", bus.din, bus.wen); end
`else
        checks++; if (bus.din !== 4'h5 || bus.wen !== 1'b1) begin errors++; $display("FAIL tag_din got %h/%b exp 5/1", bus.din, bus.wen); end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.full = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_all_valid();
        test_full();
        test_early_drop(4'b1101, 2'd2);
        test_early_drop(4'b1001, 2'd3);
        test_early_drop(4'b0001, 2'd0);
        test_async_reset();
        test_tag();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
